// File: rtl/peak_search.sv
// peak_search: per-packet |X|^2 peak finder over a bin window, one result beat per FFT packet.
module peak_search #(
    parameter int DATA_WIDTH = 18,
    parameter int BATCH_SIZE = 1024,
    parameter int CHANNELS   = 2,
    parameter int BIN_LO     = 1,
    parameter int BIN_HI     = 1023,
    parameter int IDX_WIDTH  = $clog2(BATCH_SIZE),
    parameter int CH_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sink_sop,
    input  logic                    sink_eop,
    input  logic                    sink_valid,
    input  logic [CH_WIDTH-1:0]     sink_channel,
    input  logic [DATA_WIDTH-1:0]   sink_re,
    input  logic [DATA_WIDTH-1:0]   sink_im,
    output logic                    source_valid,
    input  logic                    source_ready,
    output logic [CH_WIDTH-1:0]     source_channel,
    output logic [IDX_WIDTH-1:0]    source_bin,
    output logic [2*DATA_WIDTH-1:0] source_mag,
    output logic [DATA_WIDTH-1:0]   source_re,
    output logic [DATA_WIDTH-1:0]   source_im,
    output logic                    err_length,
    output logic                    err_sop,
    output logic [7:0]              drop_count
);
    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(BATCH_SIZE - 1);
    localparam logic [IDX_WIDTH-1:0] LO   = IDX_WIDTH'(BIN_LO);

    typedef enum logic {IDLE, IN_PKT} state_t;
    state_t state;

    logic [IDX_WIDTH-1:0] cnt, bin_now, bin0, bin1, best_bin;
    logic [CH_WIDTH-1:0] ch, ch_now, ch0, ch1, best_ch;
    logic accept, v0, done0, v1, done1, done2, in_win, better;
    logic signed [DATA_WIDTH-1:0] re0, im0, re1, im1, best_re, best_im;
    logic signed [2*DATA_WIDTH-1:0] rr, ii;
    logic [2*DATA_WIDTH-1:0] mag1, best_mag;

    assign accept  = sink_valid & (sink_sop | (state == IN_PKT));
    assign bin_now = sink_sop ? '0 : cnt + 1'b1;
    assign ch_now  = sink_sop ? sink_channel : ch;
    assign rr      = re0 * re0;
    assign ii      = im0 * im0;
    assign in_win  = (int'(bin1) >= BIN_LO) && (int'(bin1) <= BIN_HI);
    // bins arrive in order, so the first in-window bin is always BIN_LO
    assign better  = v1 & in_win & ((bin1 == LO) | (mag1 > best_mag));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ch         <= '0;
            err_length <= 1'b0;
            err_sop    <= 1'b0;
            v0         <= 1'b0;
            done0      <= 1'b0;
            bin0       <= '0;
            ch0        <= '0;
            re0        <= '0;
            im0        <= '0;
        end else begin
            v0    <= accept;
            done0 <= accept & sink_eop & (bin_now == LAST);
            bin0  <= bin_now;
            ch0   <= ch_now;
            re0   <= sink_re;
            im0   <= sink_im;
            if (accept) begin
                cnt   <= bin_now;
                ch    <= ch_now;
                state <= sink_eop ? IDLE : IN_PKT;
                if (sink_sop && state == IN_PKT) err_sop <= 1'b1;
                if (sink_eop && bin_now != LAST) err_length <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1       <= 1'b0;
            done1    <= 1'b0;
            bin1     <= '0;
            ch1      <= '0;
            re1      <= '0;
            im1      <= '0;
            mag1     <= '0;
            done2    <= 1'b0;
            best_bin <= '0;
            best_ch  <= '0;
            best_re  <= '0;
            best_im  <= '0;
            best_mag <= '0;
        end else begin
            v1    <= v0;
            done1 <= v0 & done0;
            bin1  <= bin0;
            ch1   <= ch0;
            re1   <= re0;
            im1   <= im0;
            mag1  <= rr + ii;
            done2 <= v1 & done1;
            if (better) begin
                best_bin <= bin1;
                best_ch  <= ch1;
                best_re  <= re1;
                best_im  <= im1;
                best_mag <= mag1;
            end
        end
    end

    // best_* holds the finished packet for exactly one edge after done2 rises
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            source_valid   <= 1'b0;
            source_channel <= '0;
            source_bin     <= '0;
            source_mag     <= '0;
            source_re      <= '0;
            source_im      <= '0;
            drop_count     <= '0;
        end else if (done2) begin
            if (!source_valid || source_ready) begin
                source_valid   <= 1'b1;
                source_channel <= best_ch;
                source_bin     <= best_bin;
                source_mag     <= best_mag;
                source_re      <= best_re;
                source_im      <= best_im;
            end else if (drop_count != 8'hff) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (source_ready) begin
            source_valid <= 1'b0;
        end
    end
endmodule
